// File: rtl/my_types_pkg.sv
// rtl/my_types_pkg.sv - shared types for the forwarding scoreboard
package my_types_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int FWD_SEL_REG = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic                  is_load;
  } fwd_entry_t;

  // fwd_sel_t: width is the SELW module parameter, so selects are declared as logic [SELW-1:0]
  // at each use site instead of as a package typedef.

endpackage

// File: rtl/forward_scoreboard_if.sv
// rtl/forward_scoreboard_if.sv - execute-side control bundle of the forwarding scoreboard
interface forward_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int SELW    = 2
);
  logic                          pipe_en;
  logic                          flush;
  logic                          fwd_disable;
  logic [NUM_SRC-1:0][4:0]       ex_src_addr;
  logic [NUM_SRC-1:0]            ex_src_used;
  logic                          ex_wr_en;
  logic [4:0]                    ex_wr_addr;
  logic                          ex_is_load;
  logic [NUM_SRC-1:0][SELW-1:0]  fwd_sel;
  logic                          stall;
  logic [31:0]                   stall_count;

  modport fsb (
    input  pipe_en, flush, fwd_disable, ex_src_addr, ex_src_used,
           ex_wr_en, ex_wr_addr, ex_is_load,
    output fwd_sel, stall, stall_count
  );

  modport tb (
    output pipe_en, flush, fwd_disable, ex_src_addr, ex_src_used,
           ex_wr_en, ex_wr_addr, ex_is_load,
    input  fwd_sel, stall, stall_count
  );
endinterface

// File: rtl/forward_scoreboard_fwd_match.sv
// rtl/forward_scoreboard_fwd_match.sv - per-operand priority match over the in-flight entries
module fwd_match
  import my_types_pkg::*;
#(
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 1,
  parameter int SELW       = $clog2(FWD_STAGES + 1)
) (
  input  logic                             used,
  input  logic [REG_ADDR_W-1:0]            addr,
  input  logic                             fwd_disable,
  input  fwd_entry_t [FWD_STAGES-1:0]      entries,
  output logic [SELW-1:0]                  sel,
  output logic                             stall_req
);

  logic found;

  // Lowest index is the youngest producer; once it hits, older entries are ignored.
  always_comb begin
    sel       = SELW'(FWD_SEL_REG);
    stall_req = 1'b0;
    found     = 1'b0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      if (!found && used && (addr != '0) && entries[k].valid && (entries[k].addr == addr)) begin
        found = 1'b1;
        if (fwd_disable) begin
          stall_req = 1'b1;
        end else if (entries[k].is_load && (k < LOAD_STAGE)) begin
          stall_req = 1'b1;
        end else begin
          sel = SELW'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// rtl/forward_scoreboard.sv - shift-scoreboard of in-flight writes with forwarding selects and load-use stalls
module forward_scoreboard
  import my_types_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 1,
  parameter int SELW       = $clog2(FWD_STAGES + 1)
) (
  input logic                 CLK,
  input logic                 nRST,
  forward_scoreboard_if.fsb   bus
);

  fwd_entry_t [FWD_STAGES-1:0]   entries;
  logic [NUM_SRC-1:0]            stall_req;
  logic [NUM_SRC-1:0][SELW-1:0]  sel;
  logic [31:0]                   stall_count;
  logic                          stall;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_match #(
      .FWD_STAGES (FWD_STAGES),
      .LOAD_STAGE (LOAD_STAGE),
      .SELW       (SELW)
    ) u_match (
      .used        (bus.ex_src_used[s]),
      .addr        (bus.ex_src_addr[s]),
      .fwd_disable (bus.fwd_disable),
      .entries     (entries),
      .sel         (sel[s]),
      .stall_req   (stall_req[s])
    );
  end

  assign stall            = |stall_req;
  assign bus.stall        = stall;
  assign bus.fwd_sel      = sel;
  assign bus.stall_count  = stall_count;

  // A stalled or flushed execute instruction enters the shift as a bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      entries     <= '0;
      stall_count <= '0;
    end else if (bus.pipe_en) begin
      for (int k = FWD_STAGES - 1; k > 0; k--) begin
        entries[k] <= entries[k-1];
      end
      entries[0].valid   <= bus.ex_wr_en & ~stall & ~bus.flush;
      entries[0].addr    <= bus.ex_wr_addr;
      entries[0].is_load <= bus.ex_is_load;
      if (stall && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb/tb_forward_scoreboard.sv - directed vector bench for forward_scoreboard
module tb_forward_scoreboard;

  logic CLK;
  logic nRST;

  forward_scoreboard_if #(.NUM_SRC(2), .SELW(2)) bus  ();
  forward_scoreboard_if #(.NUM_SRC(2), .SELW(2)) bus3 ();

  forward_scoreboard #(.NUM_SRC(2), .FWD_STAGES(2), .LOAD_STAGE(1), .SELW(2)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.fsb)
  );

  forward_scoreboard #(.NUM_SRC(2), .FWD_STAGES(3), .LOAD_STAGE(2), .SELW(2)) dut3 (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus3.fsb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        p, f, d;
    logic [4:0]  a0, a1;
    logic [1:0]  used;
    logic        we;
    logic [4:0]  wa;
    logic        ld;
    logic [1:0]  s0, s1;
    logic        st;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];
  int   passed;
  int   total;

  function automatic vec_t mk(input logic p, input logic f, input logic d,
                              input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used,
                              input logic we, input logic [4:0] wa, input logic ld,
                              input logic [1:0] s0, input logic [1:0] s1, input logic st,
                              input logic [31:0] cnt);
    vec_t v;
    v.p = p; v.f = f; v.d = d; v.a0 = a0; v.a1 = a1; v.used = used;
    v.we = we; v.wa = wa; v.ld = ld; v.s0 = s0; v.s1 = s1; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic p, input logic f, input logic d,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used,
                       input logic we, input logic [4:0] wa, input logic ld);
    bus.pipe_en = p; bus.flush = f; bus.fwd_disable = d;
    bus.ex_src_addr[0] = a0; bus.ex_src_addr[1] = a1; bus.ex_src_used = used;
    bus.ex_wr_en = we; bus.ex_wr_addr = wa; bus.ex_is_load = ld;
  endtask

  task automatic drive3(input logic p, input logic [4:0] a0, input logic [1:0] used,
                        input logic we, input logic [4:0] wa, input logic ld);
    bus3.pipe_en = p; bus3.flush = 1'b0; bus3.fwd_disable = 1'b0;
    bus3.ex_src_addr[0] = a0; bus3.ex_src_addr[1] = 5'd0; bus3.ex_src_used = used;
    bus3.ex_wr_en = we; bus3.ex_wr_addr = wa; bus3.ex_is_load = ld;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    //            p  f  d  a0  a1  used   we wa  ld   s0 s1 st cnt
    vecs[0]  = mk(1, 0, 0, 1,  2,  2'b11, 1, 3,  0,   0, 0, 0, 0);  // add r3
    vecs[1]  = mk(1, 0, 0, 3,  0,  2'b01, 1, 6,  0,   1, 0, 0, 0);  // rs=r3 from MEM
    vecs[2]  = mk(1, 0, 0, 0,  3,  2'b10, 0, 0,  0,   0, 2, 0, 0);  // rt=r3 from WB
    vecs[3]  = mk(1, 0, 0, 0,  0,  2'b00, 1, 5,  1,   0, 0, 0, 0);  // lw r5
    vecs[4]  = mk(1, 0, 0, 5,  5,  2'b11, 1, 8,  0,   0, 0, 1, 0);  // load-use stall
    vecs[5]  = mk(1, 0, 0, 5,  5,  2'b11, 1, 8,  0,   2, 2, 0, 1);  // forward from WB
    vecs[6]  = mk(1, 0, 0, 0,  0,  2'b00, 1, 7,  0,   0, 0, 0, 1);  // r7
    vecs[7]  = mk(1, 0, 0, 0,  0,  2'b00, 1, 7,  0,   0, 0, 0, 1);  // r7 again
    vecs[8]  = mk(1, 0, 0, 7,  8,  2'b11, 1, 0,  0,   1, 0, 0, 1);  // youngest wins, write r0
    vecs[9]  = mk(1, 0, 0, 0,  7,  2'b11, 0, 0,  0,   0, 2, 0, 1);  // r0 never matches
    vecs[10] = mk(0, 0, 0, 0,  0,  2'b00, 1, 9,  1,   0, 0, 0, 1);  // held, no shift
    vecs[11] = mk(1, 0, 0, 0,  0,  2'b00, 1, 9,  1,   0, 0, 0, 1);  // lw r9
    vecs[12] = mk(0, 0, 0, 9,  0,  2'b01, 1, 2,  0,   0, 0, 1, 1);  // stall while held
    vecs[13] = mk(0, 0, 0, 9,  0,  2'b01, 1, 2,  0,   0, 0, 1, 1);  // held stall not counted
    vecs[14] = mk(1, 0, 0, 9,  0,  2'b01, 1, 2,  0,   0, 0, 1, 1);  // stall advance
    vecs[15] = mk(1, 0, 0, 9,  0,  2'b01, 1, 2,  0,   2, 0, 0, 2);  // forward after bubble
    vecs[16] = mk(1, 0, 0, 0,  0,  2'b00, 1, 10, 1,   0, 0, 0, 2);  // lw r10
    vecs[17] = mk(1, 1, 0, 10, 2,  2'b11, 1, 11, 0,   0, 2, 1, 2);  // stall plus flush
    vecs[18] = mk(1, 1, 0, 10, 0,  2'b01, 1, 12, 0,   2, 0, 0, 3);  // flushed write r12
    vecs[19] = mk(1, 0, 0, 12, 0,  2'b01, 0, 0,  0,   0, 0, 0, 3);  // r12 not in MEM
    vecs[20] = mk(1, 0, 0, 12, 0,  2'b01, 0, 0,  0,   0, 0, 0, 3);  // r12 not in WB
    vecs[21] = mk(1, 0, 1, 0,  0,  2'b00, 1, 4,  0,   0, 0, 0, 3);  // interlock: add r4
    vecs[22] = mk(1, 0, 1, 4,  0,  2'b01, 1, 13, 0,   0, 0, 1, 3);  // stall 1
    vecs[23] = mk(1, 0, 1, 4,  0,  2'b01, 1, 13, 0,   0, 0, 1, 4);  // stall 2
    vecs[24] = mk(1, 0, 1, 4,  0,  2'b01, 1, 13, 0,   0, 0, 0, 5);  // released, sel 0
    vecs[25] = mk(0, 0, 1, 13, 0,  2'b01, 0, 0,  0,   0, 0, 1, 5);  // interlock on r13
    vecs[26] = mk(0, 0, 0, 13, 0,  2'b01, 0, 0,  0,   1, 0, 0, 5);  // toggle same cycle

    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    drive3(0, 0, 2'b00, 0, 0, 0);
    @(negedge CLK);
    #1;
    check("rst_sel0", 32'(bus.fwd_sel[0]), 32'd0);
    check("rst_sel1", 32'(bus.fwd_sel[1]), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_count", bus.stall_count, 32'd0);
    nRST = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      drive(vecs[i].p, vecs[i].f, vecs[i].d, vecs[i].a0, vecs[i].a1, vecs[i].used,
            vecs[i].we, vecs[i].wa, vecs[i].ld);
      #1;
      check($sformatf("v%0d_sel0", i), 32'(bus.fwd_sel[0]), 32'(vecs[i].s0));
      check($sformatf("v%0d_sel1", i), 32'(bus.fwd_sel[1]), 32'(vecs[i].s1));
      check($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].st));
      check($sformatf("v%0d_count", i), bus.stall_count, vecs[i].cnt);
    end

    // Three-stage variant: lw r9 then a user stalls two advances, then forwards from WB.
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    drive3(1, 0, 2'b00, 1, 9, 1);
    @(negedge CLK);
    drive3(1, 9, 2'b01, 1, 3, 0);
    #1;
    check("d3_stall_a", 32'(bus3.stall), 32'd1);
    check("d3_sel_a", 32'(bus3.fwd_sel[0]), 32'd0);
    @(negedge CLK);
    #1;
    check("d3_stall_b", 32'(bus3.stall), 32'd1);
    check("d3_count_b", bus3.stall_count, 32'd1);
    @(negedge CLK);
    #1;
    check("d3_stall_c", 32'(bus3.stall), 32'd0);
    check("d3_sel_c", 32'(bus3.fwd_sel[0]), 32'd3);
    check("d3_count_c", bus3.stall_count, 32'd2);
    drive3(0, 0, 2'b00, 0, 0, 0);

    // Asynchronous reset in the middle of a load-use stall.
    @(negedge CLK);
    drive(1, 0, 0, 0, 0, 2'b00, 1, 20, 1);
    @(negedge CLK);
    drive(1, 0, 0, 20, 0, 2'b01, 1, 21, 0);
    #1;
    check("mid_stall", 32'(bus.stall), 32'd1);
    check("mid_count", bus.stall_count, 32'd5);
    #1;
    nRST = 1'b0;
    #1;
    check("arst_stall", 32'(bus.stall), 32'd0);
    check("arst_count", bus.stall_count, 32'd0);
    check("arst_count3", bus3.stall_count, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("post_rst_stall", 32'(bus.stall), 32'd0);
    check("post_rst_sel", 32'(bus.fwd_sel[0]), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised successor to the execute-stage forwarding unit: owns a registered shift-scoreboard of in-flight register writes for `FWD_STAGES` downstream stages. It produces per-operand forwarding selects for `NUM_SRC` source operands and generates load-use stalls with automatic bubble insertion. It also supports an interlock-only mode and keeps a saturating stall counter. It sits between decode/execute control and the hazard/pipeline-enable logic of each core.

## Interface

Parameters:
- `NUM_SRC`, 2: number of execute source operands (rs, rt, …).
- `FWD_STAGES`, 2: tracked stages after execute; index 0 = MEM, index `FWD_STAGES-1` = WB.
- `LOAD_STAGE`, 1: first stage index at which load data is forwardable; must be in `1..FWD_STAGES-1`.
- `SELW`, `$clog2(FWD_STAGES+1)`: select width.

Ports:
- `CLK`  in  1  clock. One clock; reset is asynchronous and active-low.
- `nRST`  in  1  asynchronous active-low reset.
- `pipe_en`  in  1  pipeline advance enable (ihit & ~global stall).
- `flush`  in  1  execute instruction squashed this cycle.
- `fwd_disable`  in  1  interlock-only mode.
- `ex_src_addr`  in  `NUM_SRC`×5  execute source register addresses.
- `ex_src_used`  in  `NUM_SRC`  source actually read.
- `ex_wr_en`  in  1  execute instruction writes a register.
- `ex_wr_addr`  in  5  execute destination register.
- `ex_is_load`  in  1  execute instruction is a load.
- `fwd_sel`  out  `NUM_SRC`×`SELW`  0 = register file; k+1 = stage k result.
- `stall`  out  1  hold execute and insert bubble.
- `stall_count`  out  32  saturating count of stall-advance cycles.

## Operation

- Entry: `{valid, addr[4:0], is_load}`; `FWD_STAGES` entries; reset all invalid.
- Match of source s on entry k: `ex_src_used[s]`, `entry[k].valid`, `entry[k].addr == ex_src_addr[s]`, addr ≠ 0.
- The youngest match (lowest k) wins. Older matches are ignored.
- Forward mode (`fwd_disable=0`):
  - Youngest match k not a load, or k ≥ `LOAD_STAGE`: `fwd_sel[s] = k+1`.
  - Youngest match is a load and k < `LOAD_STAGE`: source s demands a stall, and `fwd_sel[s] = 0`.
- Interlock mode (`fwd_disable=1`): every `fwd_sel` is 0. Any match in any entry demands a stall.
- `stall` = OR of the per-source demands. It is combinational from registered entries and current inputs, and is independent of `pipe_en`.
- On a cycle with `pipe_en=1`:
  - Entries shift: k → k+1. The old WB entry drops out.
  - Entry 0 loads `{ex_wr_en & ~stall & ~flush, ex_wr_addr, ex_is_load}`. A stall or flush inserts a bubble.
  - If `stall=1`, `stall_count` increments, saturating at `32'hFFFF_FFFF`.
- On a cycle with `pipe_en=0`: nothing changes. `stall`/`fwd_sel` still track the inputs.
- Writes with `ex_wr_addr=0` may be stored but never match.

## Timing

- Reset (async, `nRST` low): all entries invalid, `stall_count=0`. Outputs settle to `fwd_sel=0` and `stall=0` with reset held.
- Outputs have zero-cycle latency from inputs; the scoreboard updates on the `CLK` rising edge.
- Load-use: a dependent instruction immediately behind a load stalls for `LOAD_STAGE` advancing cycles. It then forwards from stage `LOAD_STAGE`.
- Interlock mode: a dependent instruction stalls until the producer leaves WB, i.e. `FWD_STAGES - k` advances after matching at k.
- `stall` and `flush` together: a single bubble is inserted, and the stall counts.
- Reset asserted mid-stall: the stall drops immediately and the in-flight entries are lost.
- `fwd_disable` is sampled every cycle. A toggle takes effect the same cycle.

## Structure

- Shared package `my_types_pkg`: `fwd_entry_t` struct, `FWD_SEL_REG = 0` constant.
- Also add a `fwd_sel_t` width note in `my_types_pkg` (`SELW` is a module parameter).
- Interface `forward_scoreboard_if` with `fsb` and `tb` modports.
- Sub-module `fwd_match`: combinational priority encoder. It takes one source plus the entry vector and returns sel and stall-demand. `forward_scoreboard` instantiates it `NUM_SRC` times via generate.

## Test plan

Defaults 2/2/1 unless noted.
- **Back-to-back ALU:** add r3; next uses r3 as rs → `fwd_sel[0]=1`, `stall=0`. One advance later, an instruction reading r3 → `fwd_sel=2`.
- **Load-use:** lw r5, then a user of r5 → `stall=1` for one advance and entry 0 becomes a bubble. Next cycle `fwd_sel=2` (WB), `stall=0`, `stall_count=1`.
- **Priority and r0:** r7 written at both MEM and WB → `fwd_sel=1`. A write to r0 followed by a read of r0 → `fwd_sel=0`, no stall.
- **Interlock mode:** `fwd_disable=1`, add r4 then a user of r4 → stall for 2 advances, then `fwd_sel=0`. `pipe_en=0` cycles neither shift nor count.
- **Parametrised depth:** `FWD_STAGES=3`, `LOAD_STAGE=2`, lw r9 then a user → 2 stall advances, then `fwd_sel=3`.
- **Flush/reset:** `flush` with `ex_wr_en=1` → entry 0 invalid, no later match. Assert `nRST` low during a stall → `stall=0` and `stall_count=0` asynchronously.
